// File: rtl/secure_reg_bank.sv
// Write-protected register bank: two-key unlock with relock timeout,
// sticky per-entry write locks and a sequential zeroize sweep.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   LOCKED    | writes rejected, waiting for KEY0
//   KEY1_WAIT | KEY0 seen, waiting for KEY1 before timer expires
//   UNLOCKED  | writes accepted until timer expires or relock
//   ZEROIZE   | clearing entry zidx, one entry per cycle
module secure_reg_bank #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 8,
    parameter int                ADDR_W   = 3,
    parameter logic [DATA_W-1:0] KEY0     = 32'hA5A5_0F0F,
    parameter logic [DATA_W-1:0] KEY1     = 32'h5A5A_F0F0,
    parameter int                TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_data,
    input  logic              relock,
    input  logic              zeroize,
    input  logic              wr_en,
    input  logic              wr_lock,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              key_fail,
    output logic              unlocked,
    output logic              busy
);

    localparam int                IDX_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int                TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [ADDR_W:0]   NREGS_X  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_KEY1_WAIT,
        S_UNLOCKED,
        S_ZEROIZE
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [IDX_W-1:0]   zidx, zidx_nxt;
    logic               key_fail_nxt;

    logic [DATA_W-1:0]  mem [NUM_REGS];
    logic [NUM_REGS-1:0] lock;

    logic [IDX_W-1:0]   widx, ridx;
    logic               waddr_ok, raddr_ok, wr_ok;

    assign widx     = wr_addr[IDX_W-1:0];
    assign ridx     = rd_addr[IDX_W-1:0];
    assign waddr_ok = ({1'b0, wr_addr} < NREGS_X);
    assign raddr_ok = ({1'b0, rd_addr} < NREGS_X);
    assign wr_ok    = wr_en && (state == S_UNLOCKED) && waddr_ok && !lock[widx] && !zeroize;

    assign unlocked = (state == S_UNLOCKED);
    assign busy     = (state == S_ZEROIZE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOCKED;
            timer <= '0;
            zidx  <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            zidx  <= zidx_nxt;
        end
    end

    // Priority inside each live state: zeroize > relock > timeout > key.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        zidx_nxt     = zidx;
        key_fail_nxt = 1'b0;
        case (state)
            S_LOCKED: begin
                if (zeroize) begin
                    state_nxt = S_ZEROIZE;
                    zidx_nxt  = '0;
                end else if (key_valid) begin
                    if (key_data == KEY0) begin
                        state_nxt = S_KEY1_WAIT;
                        timer_nxt = TMR_LOAD;
                    end else begin
                        key_fail_nxt = 1'b1;
                    end
                end
            end
            S_KEY1_WAIT: begin
                timer_nxt = timer - TMR_ONE;
                if (zeroize) begin
                    state_nxt = S_ZEROIZE;
                    timer_nxt = '0;
                    zidx_nxt  = '0;
                end else if (relock) begin
                    state_nxt = S_LOCKED;
                    timer_nxt = '0;
                end else if (timer == TMR_ONE) begin
                    state_nxt = S_LOCKED;
                end else if (key_valid) begin
                    if (key_data == KEY1) begin
                        state_nxt = S_UNLOCKED;
                        timer_nxt = TMR_LOAD;
                    end else begin
                        state_nxt    = S_LOCKED;
                        timer_nxt    = '0;
                        key_fail_nxt = 1'b1;
                    end
                end
            end
            S_UNLOCKED: begin
                timer_nxt = timer - TMR_ONE;
                if (zeroize) begin
                    state_nxt = S_ZEROIZE;
                    timer_nxt = '0;
                    zidx_nxt  = '0;
                end else if (relock) begin
                    state_nxt = S_LOCKED;
                    timer_nxt = '0;
                end else if (timer == TMR_ONE) begin
                    state_nxt = S_LOCKED;
                end
            end
            S_ZEROIZE: begin
                zidx_nxt = zidx + IDX_ONE;
                if (zidx == LAST_IDX) begin
                    state_nxt = S_LOCKED;
                    zidx_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_LOCKED;
                timer_nxt = '0;
                zidx_nxt  = '0;
            end
        endcase
    end

    // Lock bits survive zeroize; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            lock <= '0;
        end else begin
            if (state == S_ZEROIZE) begin
                mem[zidx] <= '0;
            end else if (wr_ok) begin
                mem[widx] <= wr_data;
            end
            if (wr_ok && wr_lock) lock[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            key_fail <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= (raddr_ok && state != S_ZEROIZE) ? mem[ridx] : '0;
            wr_ack   <= wr_ok;
            wr_err   <= wr_en && !wr_ok;
            key_fail <= key_fail_nxt;
        end
    end

endmodule
